// File: rtl/prbs31_err_monitor.sv
// prbs31_err_monitor
// Self-synchronising PRBS31 (x^31 + x^28 + 1) receive monitor. Every accepted
// bit is checked against the prediction from the last 31 received bits. The
// bit is then shifted in, so the monitor follows whatever sequence phase
// arrives. A FILL/HUNT/LOCKED state machine qualifies the lock. While locked,
// errors and bits are counted into saturating BER counters.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, ACTIVE-HIGH (name inherited from the top)
//   bit_in     received serial bit
//   bit_valid  qualifies bit_in; everything stalls while low
//   clear      zeroes err_count/bit_count and both saturation flags
//   locked     high while the FSM is in LOCKED
//   err_pulse  one cycle high when the last accepted bit mismatched in LOCKED
//   err_count  saturating count of errors seen in LOCKED
//   bit_count  saturating count of bits accepted in LOCKED
//   err_sat    err_count has reached all-ones (sticky until clear/reset)
//   bit_sat    bit_count has reached all-ones (sticky until clear/reset)
module prbs31_err_monitor #(
  parameter int LOCK_COUNT  = 64,
  parameter int WINDOW      = 256,
  parameter int LOSS_THRESH = 8,
  parameter int ERR_W       = 16,
  parameter int BIT_W       = 24
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [BIT_W-1:0] bit_count,
  output logic             err_sat,
  output logic             bit_sat
);
  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int WIN_W  = $clog2(WINDOW + 1);
  localparam int WERR_W = $clog2(LOSS_THRESH + 1);

  // Terminal values compared against the count *before* the increment.
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_COUNT - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
  localparam logic [WERR_W-1:0] WERR_LAST = WERR_W'(LOSS_THRESH - 1);
  // One below all-ones: the increment from here sets the sticky flag.
  localparam logic [ERR_W-1:0]  ERR_PRE   = ~ERR_W'(1);
  localparam logic [BIT_W-1:0]  BIT_PRE   = ~BIT_W'(1);

  typedef enum logic [1:0] {FILL, HUNT, LOCKED} state_t;

  state_t            state;
  logic [30:0]       sr;
  logic [4:0]        fill_cnt;
  logic [RUN_W-1:0]  run_cnt;
  logic [WIN_W-1:0]  win_cnt;
  logic [WERR_W-1:0] win_err;

  logic pred, zero_run, err, inc_bit, inc_err;

  assign pred     = sr[27] ^ sr[30];
  // A legal PRBS31 stream never has more than 30 zeros in a row. An all-zero
  // history plus another zero is therefore a dead line, even though it
  // "matches" the all-zero prediction.
  assign zero_run = (sr == '0) && !bit_in;
  assign err      = (bit_in ^ pred) | zero_run;
  assign inc_bit  = bit_valid && (state == LOCKED);
  assign inc_err  = inc_bit && err;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state     <= FILL;
      sr        <= '0;
      fill_cnt  <= '0;
      run_cnt   <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
      bit_count <= '0;
      err_sat   <= 1'b0;
      bit_sat   <= 1'b0;
    end else begin
      err_pulse <= inc_err;

      if (bit_valid) begin
        sr <= {sr[29:0], bit_in};
        case (state)
          FILL: begin
            // History is not yet trustworthy, so errors are ignored here.
            if (fill_cnt == 5'd30) begin
              state   <= HUNT;
              run_cnt <= '0;
            end else begin
              fill_cnt <= fill_cnt + 5'd1;
            end
          end
          HUNT: begin
            if (err) begin
              run_cnt <= '0;
            end else if (run_cnt == RUN_LAST) begin
              state   <= LOCKED;
              locked  <= 1'b1;
              win_cnt <= '0;
              win_err <= '0;
            end else begin
              run_cnt <= run_cnt + 1'b1;
            end
          end
          LOCKED: begin
            // Loss takes priority over a window roll-over on the same bit.
            if (err && (win_err == WERR_LAST)) begin
              state   <= HUNT;
              locked  <= 1'b0;
              run_cnt <= '0;
            end else if (win_cnt == WIN_LAST) begin
              win_cnt <= '0;
              win_err <= '0;
            end else begin
              win_cnt <= win_cnt + 1'b1;
              win_err <= win_err + WERR_W'(err);
            end
          end
          default: begin
            state  <= FILL;
            locked <= 1'b0;
          end
        endcase
      end

      // BER counters: clear beats a coincident increment.
      if (clear) begin
        err_count <= '0;
        bit_count <= '0;
        err_sat   <= 1'b0;
        bit_sat   <= 1'b0;
      end else begin
        if (inc_err && !err_sat) begin
          err_count <= err_count + 1'b1;
          if (err_count == ERR_PRE) err_sat <= 1'b1;
        end
        if (inc_bit && !bit_sat) begin
          bit_count <= bit_count + 1'b1;
          if (bit_count == BIT_PRE) bit_sat <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_prbs31_err_monitor.sv
// Directed bench for prbs31_err_monitor. A reference PRBS31 generator
// (seed 1, tap 27^30, output bit 30) produces the clean stream. Bits are
// indexed from 0 after each reset. Lock is entered on bit 94, and locked
// windows start at bit 95 + 256*k. dut drives default widths.
// d2 uses ERR_W=4, BIT_W=8 and shares every input with dut.
module tb_prbs31_err_monitor;
  logic clk, rst_n, bit_in, bit_valid, clear;
  logic        locked, err_pulse, err_sat, bit_sat;
  logic [15:0] err_count;
  logic [23:0] bit_count;
  logic        d2_locked, d2_err_pulse, d2_err_sat, d2_bit_sat;
  logic [3:0]  d2_err_count;
  logic [7:0]  d2_bit_count;

  int nchk = 0;
  int nfail = 0;
  logic [30:0] gen;
  int idx;

  prbs31_err_monitor dut (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
    .bit_count(bit_count), .err_sat(err_sat), .bit_sat(bit_sat)
  );

  prbs31_err_monitor #(.ERR_W(4), .BIT_W(8)) d2 (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
    .locked(d2_locked), .err_pulse(d2_err_pulse), .err_count(d2_err_count),
    .bit_count(d2_bit_count), .err_sat(d2_err_sat), .bit_sat(d2_bit_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic b, input logic v);
    bit_in = b; bit_valid = v;
    @(posedge clk); #1;
  endtask

  // Send the next generator bit, optionally inverted.
  task automatic send(input logic flip);
    logic b;
    b   = gen[30] ^ flip;
    gen = {gen[29:0], gen[27] ^ gen[30]};
    step(b, 1'b1);
    idx++;
  endtask

  task automatic feed_to(input int last);
    while (idx <= last) send(1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b1; clear = 1'b0;
    step(1'b1, 1'b1);
    rst_n = 1'b0;
    gen = 31'h1; idx = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; clear = 1'b1;
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    nchk++;
    if ({locked, err_pulse, err_count, bit_count, err_sat, bit_sat} !== '0) begin
      nfail++; $display("FAIL reset_dut: outputs=%0h expected 0",
                        {locked, err_pulse, err_count, bit_count, err_sat, bit_sat});
    end
    nchk++;
    if ({d2_locked, d2_err_pulse, d2_err_count, d2_bit_count, d2_err_sat, d2_bit_sat} !== '0) begin
      nfail++; $display("FAIL reset_d2: outputs=%0h expected 0",
                        {d2_locked, d2_err_pulse, d2_err_count, d2_bit_count, d2_err_sat, d2_bit_sat});
    end
    rst_n = 1'b0; clear = 1'b0;
    gen = 31'h1; idx = 0;
  endtask

  task automatic test_lock();
    feed_to(93);
    nchk++; if (locked !== 1'b0) begin nfail++; $display("FAIL lock_early: locked=%0b expected 0", locked); end
    feed_to(94);
    nchk++; if (locked !== 1'b1) begin nfail++; $display("FAIL lock_rise: locked=%0b expected 1", locked); end
    nchk++; if (err_count !== 16'd0) begin nfail++; $display("FAIL lock_errs: err_count=%0d expected 0", err_count); end
    feed_to(1094);
    nchk++; if (bit_count !== 24'd1000) begin nfail++; $display("FAIL bit_count_1000: bit_count=%0d expected 1000", bit_count); end
    nchk++; if (err_count !== 16'd0) begin nfail++; $display("FAIL clean_errs: err_count=%0d expected 0", err_count); end
  endtask

  task automatic test_single_error();
    feed_to(1199);
    send(1'b1);  // bit 1200 inverted
    nchk++; if (err_pulse !== 1'b1) begin nfail++; $display("FAIL single_pulse: err_pulse=%0b expected 1", err_pulse); end
    nchk++; if (err_count !== 16'd1) begin nfail++; $display("FAIL single_cnt1: err_count=%0d expected 1", err_count); end
    send(1'b0);
    nchk++; if (err_pulse !== 1'b0) begin nfail++; $display("FAIL single_pulse_end: err_pulse=%0b expected 0", err_pulse); end
    feed_to(1240);  // echoes at 1228 (tap 27) and 1231 (tap 30)
    nchk++; if (err_count !== 16'd3) begin nfail++; $display("FAIL single_echo: err_count=%0d expected 3", err_count); end
    nchk++; if (locked !== 1'b1) begin nfail++; $display("FAIL single_locked: locked=%0b expected 1", locked); end
  endtask

  task automatic test_loss_relock();
    feed_to(1699);
    for (int i = 0; i < 7; i++) send(1'b1);  // bits 1700..1706
    nchk++; if (locked !== 1'b1) begin nfail++; $display("FAIL loss_7: locked=%0b expected 1", locked); end
    send(1'b1);  // bit 1707, eighth error in the window
    nchk++; if (locked !== 1'b0) begin nfail++; $display("FAIL loss_8: locked=%0b expected 0", locked); end
    nchk++; if (err_pulse !== 1'b1) begin nfail++; $display("FAIL loss_pulse: err_pulse=%0b expected 1", err_pulse); end
    nchk++; if (err_count !== 16'd11) begin nfail++; $display("FAIL loss_cnt: err_count=%0d expected 11", err_count); end
    // Last echo lands on 1738; 64 clean bits 1739..1802 relock.
    feed_to(1801);
    nchk++; if (locked !== 1'b0) begin nfail++; $display("FAIL relock_early: locked=%0b expected 0", locked); end
    feed_to(1802);
    nchk++; if (locked !== 1'b1) begin nfail++; $display("FAIL relock: locked=%0b expected 1", locked); end
    feed_to(1803);
    nchk++; if (bit_count !== 24'd1614) begin nfail++; $display("FAIL relock_bits: bit_count=%0d expected 1614", bit_count); end
    nchk++; if (err_count !== 16'd11) begin nfail++; $display("FAIL relock_errs: err_count=%0d expected 11", err_count); end
  endtask

  task automatic test_stuck_low();
    int lock_hits;
    do_reset();
    feed_to(199);
    nchk++; if (locked !== 1'b1) begin nfail++; $display("FAIL stuck_pre: locked=%0b expected 1", locked); end
    for (int i = 0; i < 39; i++) step(1'b0, 1'b1);
    nchk++; if (locked !== 1'b0) begin nfail++; $display("FAIL stuck_loss: locked=%0b expected 0", locked); end
    nchk++; if (err_count !== 16'd8) begin nfail++; $display("FAIL stuck_cnt: err_count=%0d expected 8", err_count); end
    lock_hits = 0;
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b1);
      if (locked !== 1'b0) lock_hits++;
    end
    nchk++; if (lock_hits != 0) begin nfail++; $display("FAIL stuck_relock: locked cycles=%0d expected 0", lock_hits); end
    nchk++; if (err_count !== 16'd8) begin nfail++; $display("FAIL stuck_hold: err_count=%0d expected 8", err_count); end
  endtask

  task automatic test_valid_toggle();
    do_reset();
    while (idx <= 93) begin send(1'b0); step(~gen[30], 1'b0); end
    nchk++; if (locked !== 1'b0) begin nfail++; $display("FAIL toggle_early: locked=%0b expected 0", locked); end
    send(1'b0);  // bit 94
    nchk++; if (locked !== 1'b1) begin nfail++; $display("FAIL toggle_lock: locked=%0b expected 1", locked); end
    step(~gen[30], 1'b0);
    while (idx <= 194) begin send(1'b0); step(~gen[30], 1'b0); end
    nchk++; if (bit_count !== 24'd100) begin nfail++; $display("FAIL toggle_bits: bit_count=%0d expected 100", bit_count); end
    nchk++; if (err_count !== 16'd0) begin nfail++; $display("FAIL toggle_errs: err_count=%0d expected 0", err_count); end
    clear = 1'b1;
    send(1'b1);  // bit 195 inverted, coincident with clear
    clear = 1'b0;
    nchk++; if (err_pulse !== 1'b1) begin nfail++; $display("FAIL clear_pulse: err_pulse=%0b expected 1", err_pulse); end
    nchk++; if (err_count !== 16'd0) begin nfail++; $display("FAIL clear_errs: err_count=%0d expected 0", err_count); end
    nchk++; if (bit_count !== 24'd0) begin nfail++; $display("FAIL clear_bits: bit_count=%0d expected 0", bit_count); end
    step(~gen[30], 1'b0);
    nchk++; if (err_pulse !== 1'b0) begin nfail++; $display("FAIL stall_pulse: err_pulse=%0b expected 0", err_pulse); end
    while (idx <= 240) begin send(1'b0); step(~gen[30], 1'b0); end
    // Echoes of 195 at 223 and 226 survive the clear; bits 196..240 counted.
    nchk++; if (err_count !== 16'd2) begin nfail++; $display("FAIL toggle_echo: err_count=%0d expected 2", err_count); end
    nchk++; if (bit_count !== 24'd45) begin nfail++; $display("FAIL toggle_bits2: bit_count=%0d expected 45", bit_count); end
  endtask

  task automatic test_saturation();
    do_reset();
    // One flip every 128 bits (100 + 128*j, j<20): 3 errors each, 6 per window.
    while (idx <= 2600)
      send((idx >= 100 && idx <= 2532 && ((idx - 100) % 128) == 0) ? 1'b1 : 1'b0);
    nchk++; if (d2_err_count !== 4'd15) begin nfail++; $display("FAIL sat_errs: err_count=%0d expected 15", d2_err_count); end
    nchk++; if (d2_err_sat !== 1'b1) begin nfail++; $display("FAIL sat_eflag: err_sat=%0b expected 1", d2_err_sat); end
    nchk++; if (d2_bit_count !== 8'd255) begin nfail++; $display("FAIL sat_bits: bit_count=%0d expected 255", d2_bit_count); end
    nchk++; if (d2_bit_sat !== 1'b1) begin nfail++; $display("FAIL sat_bflag: bit_sat=%0b expected 1", d2_bit_sat); end
    nchk++; if (d2_locked !== 1'b1) begin nfail++; $display("FAIL sat_locked: locked=%0b expected 1", d2_locked); end
    nchk++; if (err_count !== 16'd60) begin nfail++; $display("FAIL wide_errs: err_count=%0d expected 60", err_count); end
    nchk++; if (err_sat !== 1'b0) begin nfail++; $display("FAIL wide_eflag: err_sat=%0b expected 0", err_sat); end
    nchk++; if (bit_count !== 24'd2506) begin nfail++; $display("FAIL wide_bits: bit_count=%0d expected 2506", bit_count); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    nchk++;
    if ({locked, err_pulse, err_count, bit_count, err_sat, bit_sat} !== '0) begin
      nfail++; $display("FAIL midrst_dut: outputs=%0h expected 0",
                        {locked, err_pulse, err_count, bit_count, err_sat, bit_sat});
    end
    nchk++;
    if ({d2_locked, d2_err_pulse, d2_err_count, d2_bit_count, d2_err_sat, d2_bit_sat} !== '0) begin
      nfail++; $display("FAIL midrst_d2: outputs=%0h expected 0",
                        {d2_locked, d2_err_pulse, d2_err_count, d2_bit_count, d2_err_sat, d2_bit_sat});
    end
    // Back in FILL with empty history: the full 95-bit lock sequence repeats.
    feed_to(93);
    nchk++; if (locked !== 1'b0) begin nfail++; $display("FAIL midrst_fill: locked=%0b expected 0", locked); end
    feed_to(94);
    nchk++; if (locked !== 1'b1 || d2_locked !== 1'b1) begin
      nfail++; $display("FAIL midrst_relock: locked=%0b/%0b expected 1/1", locked, d2_locked);
    end
  endtask

  initial begin
    rst_n = 1'b1; clear = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    gen = 31'h1; idx = 0;
    #1;
    test_reset();
    test_lock();
    test_single_error();
    test_loss_relock();
    test_stuck_low();
    test_valid_toggle();
    test_saturation();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
